// File: rtl/branch_predictor_if.sv
// Fetch-side lookup, execute-side resolution and statistics bundle for the branch predictor.
// Latency: n/a (wires only).
// Backpressure: none; every signal is sampled or driven every cycle.
interface branch_predictor_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] fetchPc;
    logic                  predTaken;
    logic [DATA_WIDTH-1:0] predTarget;
    logic                  exValid;
    logic [DATA_WIDTH-1:0] exPc;
    logic                  exTaken;
    logic [DATA_WIDTH-1:0] exTarget;
    logic                  exPredTaken;
    logic [DATA_WIDTH-1:0] exPredTarget;
    logic                  flush;
    logic [DATA_WIDTH-1:0] redirectPc;
    logic [15:0]           branchCount;
    logic [15:0]           mispredictCount;

    // Pipeline side: drives fetch/execute info, consumes predictions and redirects.
    modport master (
        output fetchPc, exValid, exPc, exTaken, exTarget, exPredTaken, exPredTarget,
        input  predTaken, predTarget, flush, redirectPc, branchCount, mispredictCount
    );

    // Predictor side.
    modport slave (
        input  fetchPc, exValid, exPc, exTaken, exTarget, exPredTaken, exPredTarget,
        output predTaken, predTarget, flush, redirectPc, branchCount, mispredictCount
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters, mispredict detection and statistics.
// Latency: lookup and flush are combinational; table/count updates land on the next rising edge.
// Backpressure: none; one lookup and at most one resolution are accepted every cycle.
module branch_predictor #(
    parameter int DATA_WIDTH = 32,
    parameter int INDEX_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    branch_predictor_if.slave    bus
);
    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = DATA_WIDTH - INDEX_BITS - 2;

    logic             valid_q  [ENTRIES];
    logic             valid_d  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [TAG_W-1:0] tag_d    [ENTRIES];
    logic [DATA_WIDTH-1:0] target_q [ENTRIES];
    logic [DATA_WIDTH-1:0] target_d [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];
    logic [1:0]       ctr_d    [ENTRIES];
    logic [15:0]      branch_count_q, branch_count_d;
    logic [15:0]      mispredict_count_q, mispredict_count_d;

    logic [INDEX_BITS-1:0] f_idx, e_idx;
    logic [TAG_W-1:0]      f_tag, e_tag;
    logic                  f_hit, e_hit, pred_taken;
    logic [DATA_WIDTH-1:0] correct_pc;
    logic                  flush;

    // Fetch-side lookup: reads the registered table only, so a same-cycle update is not bypassed.
    always_comb begin
        f_idx      = bus.fetchPc[INDEX_BITS+1:2];
        f_tag      = bus.fetchPc[DATA_WIDTH-1:INDEX_BITS+2];
        f_hit      = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        pred_taken = f_hit && ctr_q[f_idx][1];
    end

    assign bus.predTaken  = pred_taken;
    assign bus.predTarget = pred_taken ? target_q[f_idx] : bus.fetchPc + DATA_WIDTH'(4);

    // Resolution: compare the carried prediction against the real next PC.
    always_comb begin
        e_idx      = bus.exPc[INDEX_BITS+1:2];
        e_tag      = bus.exPc[DATA_WIDTH-1:INDEX_BITS+2];
        e_hit      = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
        correct_pc = bus.exTaken ? bus.exTarget : bus.exPc + DATA_WIDTH'(4);
        flush      = bus.exValid &&
                     ((bus.exTaken != bus.exPredTaken) || (bus.exPredTarget != correct_pc));
    end

    assign bus.flush           = flush;
    assign bus.redirectPc      = bus.exValid ? correct_pc : '0;
    assign bus.branchCount     = branch_count_q;
    assign bus.mispredictCount = mispredict_count_q;

    // Next-state: train or replace the indexed entry and bump saturating statistics.
    always_comb begin
        valid_d            = valid_q;
        tag_d              = tag_q;
        target_d           = target_q;
        ctr_d              = ctr_q;
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (bus.exValid) begin
            if (e_hit) begin
                if (bus.exTaken) begin
                    if (ctr_q[e_idx] != 2'b11) begin
                        ctr_d[e_idx] = ctr_q[e_idx] + 2'd1;
                    end
                    target_d[e_idx] = bus.exTarget;
                end else if (ctr_q[e_idx] != 2'b00) begin
                    ctr_d[e_idx] = ctr_q[e_idx] - 2'd1;
                end
            end else begin
                // Miss (or alias): take over the slot with a weak bias toward the outcome.
                valid_d[e_idx]  = 1'b1;
                tag_d[e_idx]    = e_tag;
                target_d[e_idx] = bus.exTarget;
                ctr_d[e_idx]    = bus.exTaken ? 2'b10 : 2'b01;
            end
            if (branch_count_q != 16'hFFFF) begin
                branch_count_d = branch_count_q + 16'd1;
            end
            if (flush && (mispredict_count_q != 16'hFFFF)) begin
                mispredict_count_d = mispredict_count_q + 16'd1;
            end
        end
    end

    // State registers; reset clears the table to invalid/weak-not-taken without a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            valid_q            <= valid_d;
            tag_q              <= tag_d;
            target_q           <= target_d;
            ctr_q              <= ctr_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Randomized + directed bench for branch_predictor against a table model kept in plain arithmetic.
// Latency: checks combinational outputs each negedge; model advances on each rising edge.
// Backpressure: n/a.
module tb_branch_predictor;
    localparam int DW = 32;
    localparam int IB = 4;
    localparam int N  = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_predictor_if #(.DATA_WIDTH(DW)) bus ();

    branch_predictor #(.DATA_WIDTH(DW), .INDEX_BITS(IB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    // Behavioural model: one record per slot, counter kept as an integer 0..3.
    bit          m_valid  [N];
    logic [31:0] m_tag    [N];
    logic [31:0] m_target [N];
    int          m_ctr    [N];
    int          m_bc, m_mc;

    function automatic int idx_of(logic [31:0] pc);
        return int'((pc / 4) % N);
    endfunction

    function automatic logic [31:0] tag_of(logic [31:0] pc);
        return pc / (4 * N);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update: reset clears, otherwise apply the resolving branch.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_valid[i] = 0; m_tag[i] = 0; m_target[i] = 0; m_ctr[i] = 1;
            end
            m_bc = 0;
            m_mc = 0;
        end else if (bus.exValid === 1'b1) begin
            int i;
            logic [31:0] cpc;
            bit fl;
            i   = idx_of(bus.exPc);
            cpc = bus.exTaken ? bus.exTarget : bus.exPc + 4;
            fl  = (bus.exTaken != bus.exPredTaken) || (bus.exPredTarget != cpc);
            if (m_bc < 65535) m_bc++;
            if (fl && m_mc < 65535) m_mc++;
            if (m_valid[i] && m_tag[i] == tag_of(bus.exPc)) begin
                if (bus.exTaken) begin
                    m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                    m_target[i] = bus.exTarget;
                end else begin
                    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                end
            end else begin
                m_valid[i]  = 1;
                m_tag[i]    = tag_of(bus.exPc);
                m_target[i] = bus.exTarget;
                m_ctr[i]    = bus.exTaken ? 2 : 1;
            end
        end
    end

    // Compare process: every outputs-meaningful cycle, DUT vs model.
    always @(negedge clk) begin
        if (cmp_en) begin
            int i;
            bit pt, fl;
            logic [31:0] ptgt, cpc;
            i    = idx_of(bus.fetchPc);
            pt   = m_valid[i] && (m_tag[i] == tag_of(bus.fetchPc)) && (m_ctr[i] >= 2);
            ptgt = pt ? m_target[i] : bus.fetchPc + 4;
            cpc  = bus.exTaken ? bus.exTarget : bus.exPc + 4;
            fl   = bus.exValid && ((bus.exTaken != bus.exPredTaken) || (bus.exPredTarget != cpc));
            check("m_predTaken", 32'(bus.predTaken), 32'(pt));
            check("m_predTarget", bus.predTarget, ptgt);
            check("m_flush", 32'(bus.flush), 32'(fl));
            check("m_redirectPc", bus.redirectPc, bus.exValid ? cpc : 32'h0);
            check("m_branchCount", 32'(bus.branchCount), 32'(m_bc));
            check("m_mispredictCount", 32'(bus.mispredictCount), 32'(m_mc));
        end
    end

    task automatic drive(bit v, logic [31:0] pc, bit t, logic [31:0] tgt, bit pt, logic [31:0] ptgt);
        bus.exValid      = v;
        bus.exPc         = pc;
        bus.exTaken      = t;
        bus.exTarget     = tgt;
        bus.exPredTaken  = pt;
        bus.exPredTarget = ptgt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.fetchPc = 32'h100;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cmp_en = 1;

        // Reset state lookup.
        #1;
        check("rst_predTaken", 32'(bus.predTaken), 0);
        check("rst_predTarget", bus.predTarget, 32'h104);
        check("rst_counts", {bus.branchCount, bus.mispredictCount}, 0);

        // First taken resolution of 0x100 is a mispredict.
        drive(1, 32'h100, 1, 32'h80, 0, 32'h104);
        #1;
        check("first_flush", 32'(bus.flush), 1);
        check("first_redirect", bus.redirectPc, 32'h80);
        step();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        check("trained_predTaken", 32'(bus.predTaken), 1);
        check("trained_predTarget", bus.predTarget, 32'h80);
        check("trained_counts", {bus.branchCount, bus.mispredictCount}, {16'd1, 16'd1});

        // Saturate at strong-taken, then walk back down.
        drive(1, 32'h100, 1, 32'h80, 1, 32'h80);
        #1;
        check("correct_flush", 32'(bus.flush), 0);
        repeat (3) step();
        drive(1, 32'h100, 0, 32'h80, 1, 32'h80);
        step();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        check("sat_nt1_predTaken", 32'(bus.predTaken), 1);
        drive(1, 32'h100, 0, 32'h80, 1, 32'h80);
        step();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        check("sat_nt2_predTaken", 32'(bus.predTaken), 0);
        check("sat_nt2_predTarget", bus.predTarget, 32'h104);
        check("sat_counts", {bus.branchCount, bus.mispredictCount}, {16'd6, 16'd3});

        // Correct prediction, then right direction but wrong target.
        drive(1, 32'h100, 1, 32'h80, 1, 32'h80);
        step();
        drive(1, 32'h100, 1, 32'h80, 1, 32'h90);
        #1;
        check("wrongtgt_flush", 32'(bus.flush), 1);
        step();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        check("wrongtgt_counts", {bus.branchCount, bus.mispredictCount}, {16'd8, 16'd4});

        // Alias at the same index retags the slot.
        drive(1, 32'h140, 0, 32'h200, 0, 32'h144);
        step();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        check("alias_old_predTaken", 32'(bus.predTaken), 0);
        check("alias_old_predTarget", bus.predTarget, 32'h104);

        // Same-cycle update and lookup: old contents now, new contents next cycle.
        drive(1, 32'h100, 1, 32'h300, 0, 32'h104);
        #1;
        check("bypass_same_cycle", 32'(bus.predTaken), 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        check("bypass_next_target", bus.predTarget, 32'h300);

        // Randomized traffic over three tags per index.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] pc, tgt, cpc;
            bit t;
            pc  = 32'h100 + 4 * $urandom_range(0, 47);
            tgt = {$urandom_range(0, 255), 2'b00};
            t   = $urandom_range(0, 1);
            cpc = t ? tgt : pc + 4;
            if ($urandom_range(0, 1) == 1)
                drive($urandom_range(0, 9) < 7, pc, t, tgt, t, cpc);
            else
                drive($urandom_range(0, 9) < 7, pc, t, tgt, $urandom_range(0, 1), $urandom);
            bus.fetchPc = 32'h100 + 4 * $urandom_range(0, 47);
            step();
        end

        // Train 0x100 taken, then reset asynchronously between edges.
        drive(1, 32'h100, 1, 32'h80, 0, 32'h104);
        repeat (2) step();
        drive(0, 0, 0, 0, 0, 0);
        bus.fetchPc = 32'h100;
        #1;
        check("pre_rst_predTaken", 32'(bus.predTaken), 1);
        #1 rst = 1'b1;
        drive(1, 32'h200, 0, 32'h80, 1, 32'h80);
        #1;
        check("async_rst_predTaken", 32'(bus.predTaken), 0);
        check("async_rst_predTarget", bus.predTarget, 32'h104);
        check("async_rst_counts", {bus.branchCount, bus.mispredictCount}, 0);
        check("async_rst_flush", 32'(bus.flush), 1);
        check("async_rst_redirect", bus.redirectPc, 32'h204);
        step();
        drive(0, 0, 0, 0, 0, 0);
        #3 rst = 1'b0;
        step();
        #1;
        check("post_rst_counts", {bus.branchCount, bus.mispredictCount}, 0);
        step();

        cmp_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
